adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined two's-complement adder/subtractor for the datapath arithmetic library. It is the next generation of the fixed-width ripple-chunk adders. Operands are split into CHUNK-bit segments, and one segment is resolved per pipeline stage, so the carry chain per cycle is CHUNK bits regardless of WIDTH. The block adds a subtract mode, a signed-overflow flag and a valid/ready handshake with full backpressure, so it can sit directly between streaming producers and consumers.

## Interface
- WIDTH, 12: operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: segment width resolved per stage; NSEG = WIDTH/CHUNK stages.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- A  in  [WIDTH:1]  operand A (bit 1 = LSB).
- B  in  [WIDTH:1]  operand B.
- c0  in  1  carry-in for add mode; ignored when sub=1.
- sub  in  1  0: S = A+B+c0; 1: S = A+~B+1 (A-B).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- S  out  [WIDTH:1]  sum/difference modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH (in sub mode: 1 = no borrow).
- ovf  out  1  signed overflow: operand MSBs (after B inversion) equal and S[WIDTH] differs.

## Operation
- Accept: a beat transfers when in_valid && in_ready.
- Input conditioning at accept: Beff = sub ? ~B : B; cin = sub ? 1 : c0.
- Stage k (k = 1..NSEG) computes segment k from the carry registered by stage k-1. For stage 1 that carry is cin.
- Upper, unconsumed operand segments travel in skew registers alongside the data.
- Completed lower result segments travel in deskew registers, so all segments of one operation emerge together.
- Each stage holds a valid bit. Stage NSEG drives out_valid, S, cout and ovf directly from registers, with no combinational path from inputs.
- The MSB signs of A and Beff are carried to the last stage for ovf.
- Stall: stall = out_valid && !out_ready. On stall, every stage register (data and valid) holds.
- in_ready = !stall, which is combinational from out_ready and out_valid only.
- Bubbles are not squeezed: the whole pipe advances or freezes as one unit.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Outputs S, cout and ovf hold stable while out_valid && !out_ready.
- rst: all stage valid bits clear. S, cout and ovf clear to 0. In-flight beats are discarded. in_ready is 1 in the first cycle after reset deasserts.
- rst asserted mid-stream wins over any simultaneous accept or output handshake that cycle; neither beat counts as transferred.
- WIDTH == CHUNK degenerates to a single-stage registered adder with latency 1.

## Timing
- Latency: a beat accepted at edge t presents out_valid at edge t+NSEG, provided no stall occurs in between. Default configuration: 3 cycles.
- Each stall cycle adds exactly one cycle of latency to every in-flight beat.
- Throughput: one result per cycle with out_ready held high.
- Simultaneous output-consume and input-accept in one cycle is legal and required at full throughput.
- Reset values: out_valid=0, S=0, cout=0, ovf=0. in_ready=1 while rst=1, because stall=0; beats presented during reset are discarded.

## Test plan
All scenarios use WIDTH=12, CHUNK=4 unless noted.
- Carry across all segments: A=0xFFF, B=0x001, c0=0, sub=0 → 3 cycles later S=0x000, cout=1, ovf=0. With c0=1 and B=0x000 → same result.
- Subtract with borrow: A=0x005, B=0x007, sub=1 → S=0xFFE, cout=0, ovf=0. A=0x007, B=0x005 → S=0x002, cout=1.
- Signed overflow: A=0x7FF, B=0x001 add → S=0x800, ovf=1, cout=0. A=0x800, B=0x001 sub → S=0x7FF, ovf=1.
- Backpressure, part 1: stream 8 random beats back-to-back and drop out_ready for cycles 4-7 → in_ready=0 exactly while out_valid && !out_ready.
- Backpressure, part 2: same stream → all 8 results match the reference model in order, and S holds stable during the stall.
- Reset mid-stream plus sweep, part 1: assert rst for 1 cycle with 2 beats in flight → out_valid=0 the next cycle, S=0, and no stale beat ever appears.
- Reset mid-stream plus sweep, part 2: repeat the random-compare bench for (WIDTH, CHUNK) = (4,4), (16,4) and (32,8) → latency NSEG and bit-exact results.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: chunk-pipelined add/sub with carry/overflow flags and a stall-as-one-unit handshake.
module adder_pipe #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   S,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = WIDTH / CHUNK;
  localparam int L = NSEG - 1;
  logic             w_stall;
  logic [WIDTH-1:0] w_a [NSEG];
  logic [WIDTH-1:0] w_b [NSEG];
  logic             w_c [NSEG];
  logic [CHUNK:0]   w_sum [NSEG];
  logic             r_v [NSEG];
  logic [WIDTH-1:0] r_a [NSEG];
  logic [WIDTH-1:0] r_b [NSEG];
  logic             r_c [NSEG];
  logic             r_ovf;
  assign w_stall   = r_v[L] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_v[L];
  assign S         = r_a[L];
  assign cout      = r_c[L];
  assign ovf       = r_ovf;
  // r_a shifts right each stage: the next A segment sits at the bottom, finished sum segments enter at the top
  always_comb begin
    w_a[0] = A;
    w_b[0] = B ^ {WIDTH{sub}};
    w_c[0] = sub | c0;
    for (int k = 1; k < NSEG; k++) begin
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_c[k] = r_c[k-1];
    end
    for (int k = 0; k < NSEG; k++)
      w_sum[k] = {1'b0, w_a[k][CHUNK-1:0]} + {1'b0, w_b[k][CHUNK-1:0]} + {{CHUNK{1'b0}}, w_c[k]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_v[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) r_v[k] <= r_v[k-1];
      for (int k = 0; k < NSEG; k++) begin
        r_a[k] <= WIDTH'({w_sum[k][CHUNK-1:0], w_a[k]} >> CHUNK);
        r_b[k] <= w_b[k] >> CHUNK;
        r_c[k] <= w_sum[k][CHUNK];
      end
      // in the last stage the low segment of each operand holds its sign bit
      r_ovf <= (w_a[L][CHUNK-1] == w_b[L][CHUNK-1]) && (w_sum[L][CHUNK-1] != w_a[L][CHUNK-1]);
    end
  end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe over several (WIDTH, CHUNK) configurations.
module tb_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit done [4];
  typedef struct {
    logic [63:0] s;
    bit          cout;
    bit          ovf;
    int          acc;
    int          stl;
  } exp_t;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  genvar j;
  for (j = 0; j < 4; j++) begin : g_cfg
    localparam int W = (j == 0) ? 12 : (j == 1) ? 4 : (j == 2) ? 16 : 32;
    localparam int C = (j == 3) ? 8 : 4;
    localparam int N = W / C;
    logic rst, in_valid, in_ready, c0, sub, out_valid, out_ready, cout, ovf;
    logic [W:1] a, b, s;
    exp_t q[$];
    int stalls = 0;
    adder_pipe #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .c0(c0), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(s), .cout(cout), .ovf(ovf)
    );
    // reference: plain integer add plus a signed-range test for overflow
    function automatic exp_t model(longint x, longint y, bit ci, bit sb);
      exp_t r;
      longint m = (longint'(1) << W) - 1;
      longint half = longint'(1) << (W - 1);
      longint be = sb ? (~y & m) : y;
      longint cin = (sb || ci) ? 1 : 0;
      longint t = x + be + cin;
      longint st = ((x ^ half) - half) + ((be ^ half) - half) + cin;
      r.s = 64'(t & m);
      r.cout = ((t >> W) & 1) != 0;
      r.ovf = (st > half - 1) || (st < -half);
      r.acc = 0;
      r.stl = 0;
      return r;
    endfunction
    function automatic longint rnd();
      return (longint'($urandom) << 1 ^ longint'($urandom)) & ((longint'(1) << W) - 1);
    endfunction
    task automatic send(longint x, longint y, bit ci, bit sb);
      exp_t e = model(x, y, ci, sb);
      in_valid = 1'b1;
      a = W'(x);
      b = W'(y);
      c0 = ci;
      sub = sb;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clk);
        if (in_ready) begin
          e.acc = cyc;
          e.stl = stalls;
          q.push_back(e);
          break;
        end
        if (t == 999) chk($sformatf("cfg%0d accept_timeout", j), 64'(in_ready), 64'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask
    task automatic rand_run(int n);
      bit sdone = 1'b0;
      fork
        begin
          for (int i = 0; i < n; i++) begin
            send(rnd(), rnd(), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(3) == 0 ? 1 : 0) begin
              @(posedge clk);
              #1;
            end
          end
          sdone = 1'b1;
        end
        begin
          while (!sdone) begin
            out_ready = $urandom_range(3) != 0;
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      join
      for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
      chk($sformatf("cfg%0d drain", j), 64'(q.size()), 64'd0);
    endtask
    task automatic reset_start();
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      a = '1;
      b = '1;
      c0 = 1'b1;
      sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("cfg%0d rst_out_valid", j), 64'(out_valid), 64'd0);
      chk($sformatf("cfg%0d rst_S", j), 64'(s), 64'd0);
      chk($sformatf("cfg%0d rst_cout_ovf", j), 64'({cout, ovf}), 64'd0);
      chk($sformatf("cfg%0d rst_in_ready", j), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("cfg%0d in_ready_after_rst", j), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    endtask
    // monitor: pops the scoreboard on each output handshake and checks hold, order and latency
    initial begin
      logic [W:1] prev_s = '0;
      bit prev_stall = 1'b0;
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst !== 1'b0) begin
          prev_stall = 1'b0;
        end else begin
          chk($sformatf("cfg%0d in_ready", j), 64'(in_ready), 64'(!(out_valid && !out_ready)));
          if (prev_stall) chk($sformatf("cfg%0d S_hold", j), 64'(s), 64'(prev_s));
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              chk($sformatf("cfg%0d stale_beat", j), 64'(out_valid), 64'd0);
            end else begin
              e = q.pop_front();
              chk($sformatf("cfg%0d S", j), 64'(s), e.s);
              chk($sformatf("cfg%0d cout", j), 64'(cout), 64'(e.cout));
              chk($sformatf("cfg%0d ovf", j), 64'(ovf), 64'(e.ovf));
              chk($sformatf("cfg%0d latency", j), 64'(cyc - e.acc), 64'(N + stalls - e.stl));
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_s = s;
          if (prev_stall) stalls++;
        end
      end
    end
    if (j == 0) begin : g_dir
      initial begin
        reset_start();
        send('hFFF, 'h001, 1'b0, 1'b0);
        send('hFFF, 'h000, 1'b1, 1'b0);
        send('h005, 'h007, 1'b0, 1'b1);
        send('h007, 'h005, 1'b0, 1'b1);
        send('h7FF, 'h001, 1'b0, 1'b0);
        send('h800, 'h001, 1'b0, 1'b1);
        send('h800, 'h800, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        fork
          for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom), 1'($urandom));
          for (int i = 1; i <= 20; i++) begin
            out_ready = !(i >= 4 && i <= 7);
            @(posedge clk);
            #1;
          end
        join
        chk("cfg0 bp_drain", 64'(q.size()), 64'd0);
        send(rnd(), rnd(), 1'b0, 1'b0);
        send(rnd(), rnd(), 1'b1, 1'b1);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cfg0 midrst_out_valid", 64'(out_valid), 64'd0);
        chk("cfg0 midrst_S", 64'(s), 64'd0);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("cfg0 no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rand_run(150);
        done[j] = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        reset_start();
        rand_run(150);
        done[j] = 1'b1;
      end
    end
  end
  initial begin
    for (int t = 0; t < 40000 && !(done[0] && done[1] && done[2] && done[3]); t++) @(posedge clk);
    if (!(done[0] && done[1] && done[2] && done[3])) chk("global_timeout", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
